codes_engine: RTL and testbench

- Parametrised cheat-code (Game Genie style) engine; replaces the disabled cheat stub in the GameBoy core.
- Holds a table of up to MAX_CODES address/compare/replace entries, loaded one code per strobe from the HPS/OSD cheat loader.
- Overrides cartridge/ROM read data on the CPU data path in the same cycle as the address is presented.

---
 rtl/codes_pkg.sv | 33 +++
 rtl/codes_prio_enc.sv | 25 ++
 rtl/codes_engine.sv | 175 +++++++++++++++++
 tb/tb_codes_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/codes_pkg.sv
// Shared definitions for the cheat-code engine: code-word field offsets,
// per-slot flag record and hit-counter width.
package codes_pkg;

    localparam int HIT_CNT_W = 16;

    // Packed code word, LSB first: comp_flag, ena_flag, addr, compare, data.
    function automatic int COMP_F();
        return 0;
    endfunction

    function automatic int ENA_F();
        return 1;
    endfunction

    function automatic int ADDR_S();
        return 2;
    endfunction

    function automatic int COMP_S(input int addr_w);
        return addr_w + 2;
    endfunction

    function automatic int DATA_S(input int addr_w, input int comp_w);
        return addr_w + comp_w + 2;
    endfunction

    typedef struct packed {
        logic valid;
        logic comp_flag;
    } slot_flags_t;

endpackage

// File: rtl/codes_prio_enc.sv
// Lowest-set-bit priority encoder; reports the winning index and whether any
// request bit was set.
module codes_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so no latch can be inferred.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/codes_engine.sv
// Game Genie style cheat-code table with zero-latency read-data override.
// Optional per-slot hit counters are enabled by defining CODES_HIT_STATS_EN.
module codes_engine
    import codes_pkg::*;
#(
    parameter int MAX_CODES  = 16,
    parameter int INDEX_SIZE = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int COMP_WIDTH = 8,
    parameter int CODE_WIDTH = ADDR_WIDTH + COMP_WIDTH + DATA_WIDTH + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CODE_WIDTH-1:0] code,
    input  logic                  code_wr,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
`ifdef CODES_HIT_STATS_EN
    input  logic [INDEX_SIZE-1:0] stat_idx,
    output logic [HIT_CNT_W-1:0]  stat_count,
`endif
    output logic                  available,
    output logic                  genie_ovr,
    output logic [DATA_WIDTH-1:0] genie_data,
    output logic [INDEX_SIZE:0]   num_codes,
    output logic                  load_err
);

    localparam int L_COMP_F = COMP_F();
    localparam int L_ENA_F  = ENA_F();
    localparam int L_ADDR_S = ADDR_S();
    localparam int L_COMP_S = COMP_S(ADDR_WIDTH);
    localparam int L_DATA_S = DATA_S(ADDR_WIDTH, COMP_WIDTH);

    slot_flags_t           r_flags [MAX_CODES];
    logic [ADDR_WIDTH-1:0] r_addr  [MAX_CODES];
    logic [COMP_WIDTH-1:0] r_cmp   [MAX_CODES];
    logic [DATA_WIDTH-1:0] r_data  [MAX_CODES];
    logic [INDEX_SIZE:0]   r_num;
    logic                  r_available;
    logic                  r_load_err;

    logic                  w_cflag, w_ena;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [COMP_WIDTH-1:0] w_cmp;
    logic [DATA_WIDTH-1:0] w_data;
    logic [MAX_CODES-1:0]  w_valid, w_match, w_hit;
    logic [INDEX_SIZE-1:0] w_match_idx, w_free_idx, w_wr_slot;
    logic                  w_match_found, w_free_found;
    logic                  w_wr_en, w_clr_en, w_full, w_hit_any;
    logic [INDEX_SIZE:0]   w_num_next;
    logic [DATA_WIDTH-1:0] w_hit_data;

    assign w_cflag = code[L_COMP_F];
    assign w_ena   = code[L_ENA_F];
    assign w_addr  = code[L_ADDR_S +: ADDR_WIDTH];
    assign w_cmp   = code[L_COMP_S +: COMP_WIDTH];
    assign w_data  = code[L_DATA_S +: DATA_WIDTH];

    always_comb begin
        for (int i = 0; i < MAX_CODES; i++) begin
            w_valid[i] = r_flags[i].valid;
            w_match[i] = r_flags[i].valid && (r_addr[i] == w_addr);
        end
    end

    codes_prio_enc #(.WIDTH(MAX_CODES), .IDX_W(INDEX_SIZE)) u_match_enc (
        .i_req   (w_match),
        .o_idx   (w_match_idx),
        .o_found (w_match_found)
    );

    codes_prio_enc #(.WIDTH(MAX_CODES), .IDX_W(INDEX_SIZE)) u_free_enc (
        .i_req   (~w_valid),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    // An add to an address already in the table rewrites that slot, keeping
    // addresses unique so at most one slot can ever hit.
    always_comb begin
        w_wr_slot  = w_match_idx;
        w_wr_en    = 1'b0;
        w_clr_en   = 1'b0;
        w_full     = 1'b0;
        w_num_next = r_num;
        if (code_wr) begin
            if (w_ena) begin
                if (w_match_found) begin
                    w_wr_en = 1'b1;
                end else if (w_free_found) begin
                    w_wr_en    = 1'b1;
                    w_wr_slot  = w_free_idx;
                    w_num_next = r_num + 1'b1;
                end else begin
                    w_full = 1'b1;
                end
            end else if (w_match_found) begin
                w_clr_en   = 1'b1;
                w_num_next = r_num - 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_CODES; i++) r_flags[i] <= '0;
            r_num       <= '0;
            r_available <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            if (w_wr_en)  r_flags[w_wr_slot] <= '{valid: 1'b1, comp_flag: w_cflag};
            if (w_clr_en) r_flags[w_wr_slot].valid <= 1'b0;
            r_num       <= w_num_next;
            r_available <= (w_num_next != '0);
            r_load_err  <= w_full;
        end
    end

    // NOTE: the payload arrays have no reset; a slot's valid bit alone decides
    // whether its contents are ever looked at.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_addr[w_wr_slot] <= w_addr;
            r_cmp[w_wr_slot]  <= w_cmp;
            r_data[w_wr_slot] <= w_data;
        end
    end

    always_comb begin
        w_hit_any  = 1'b0;
        w_hit_data = data_in;
        for (int i = 0; i < MAX_CODES; i++) begin
            w_hit[i] = r_flags[i].valid && (r_addr[i] == addr_in) &&
                       (!r_flags[i].comp_flag || (r_cmp[i] == data_in[COMP_WIDTH-1:0]));
            if (w_hit[i]) begin
                w_hit_any  = 1'b1;
                w_hit_data = r_data[i];
            end
        end
    end

    assign genie_ovr  = enable && w_hit_any;
    assign genie_data = genie_ovr ? w_hit_data : data_in;
    assign available  = r_available;
    assign num_codes  = r_num;
    assign load_err   = r_load_err;

`ifdef CODES_HIT_STATS_EN
    logic [HIT_CNT_W-1:0] r_hits [MAX_CODES];
    logic [HIT_CNT_W-1:0] r_stat;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_CODES; i++) r_hits[i] <= '0;
            r_stat <= '0;
        end else begin
            for (int i = 0; i < MAX_CODES; i++) begin
                if ((w_wr_en || w_clr_en) && (w_wr_slot == INDEX_SIZE'(i)))
                    r_hits[i] <= '0;
                else if (enable && w_hit[i] && (r_hits[i] != '1))
                    r_hits[i] <= r_hits[i] + 1'b1;
            end
            r_stat <= r_hits[stat_idx];
        end
    end

    assign stat_count = r_stat;
`endif

endmodule

// File: tb/tb_codes_engine.sv
// Scoreboard bench for codes_engine: stimulus queues expected outputs, a
// negedge monitor pops and compares them.
module tb_codes_engine;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int IW  = 4;
    localparam int MC  = 16;
    localparam int CDW = AW + CW + DW + 2;

    logic           clk = 1'b0;
    logic           reset, code_wr, enable;
    logic [CDW-1:0] code;
    logic [AW-1:0]  addr_in;
    logic [DW-1:0]  data_in;
    logic           available, genie_ovr, load_err;
    logic [DW-1:0]  genie_data;
    logic [IW:0]    num_codes;
`ifdef CODES_HIT_STATS_EN
    logic [IW-1:0]  stat_idx;
    logic [15:0]    stat_count;
`endif

    codes_engine #(
        .MAX_CODES (MC), .INDEX_SIZE(IW), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .COMP_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .code       (code),
        .code_wr    (code_wr),
        .enable     (enable),
        .addr_in    (addr_in),
        .data_in    (data_in),
`ifdef CODES_HIT_STATS_EN
        .stat_idx   (stat_idx),
        .stat_count (stat_count),
`endif
        .available  (available),
        .genie_ovr  (genie_ovr),
        .genie_data (genie_data),
        .num_codes  (num_codes),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef enum {S_OVR, S_DATA, S_AVAIL, S_NUM, S_ERR, S_STAT} sig_e;
    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e.sig)
                S_OVR:   mon_act = 32'(genie_ovr);
                S_DATA:  mon_act = 32'(genie_data);
                S_AVAIL: mon_act = 32'(available);
                S_NUM:   mon_act = 32'(num_codes);
                S_ERR:   mon_act = 32'(load_err);
`ifdef CODES_HIT_STATS_EN
                S_STAT:  mon_act = 32'(stat_count);
`endif
                default: mon_act = 32'hDEAD_BEEF;
            endcase
            check(mon_e.name, mon_act, mon_e.val);
        end
    end

    task automatic expect_sig(input string name, input sig_e s, input logic [31:0] v);
        exp_q.push_back('{name: name, sig: s, val: v});
    endtask

    task automatic expect_state(input string name, input logic av, input int num, input logic err);
        expect_sig({name, ".avail"}, S_AVAIL, 32'(av));
        expect_sig({name, ".num"},   S_NUM,   32'(num));
        expect_sig({name, ".err"},   S_ERR,   32'(err));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input logic [AW-1:0] a, input logic [CW-1:0] c,
                            input logic [DW-1:0] d, input logic ena, input logic cf);
        code = {d, c, a, ena, cf};
    endtask

    // Returns one tick after the write edge, in the cycle the new entry is live.
    task automatic load(input logic [AW-1:0] a, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic ena, input logic cf);
        cyc();
        set_code(a, c, d, ena, cf);
        code_wr = 1'b1;
        cyc();
        code_wr = 1'b0;
    endtask

    task automatic look(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic en, input logic exp_ovr, input logic [DW-1:0] exp_data);
        cyc();
        addr_in = a;
        data_in = d;
        enable  = en;
        expect_sig({name, ".ovr"},  S_OVR,  32'(exp_ovr));
        expect_sig({name, ".data"}, S_DATA, 32'(exp_data));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        code_wr = 1'b0;
        code    = '0;
        enable  = 1'b1;
        addr_in = 16'h0150;
        data_in = 8'h3E;
`ifdef CODES_HIT_STATS_EN
        stat_idx = '0;
`endif
        repeat (2) cyc();
        reset = 1'b0;
        expect_sig("rst.ovr", S_OVR, 32'd0);
        expect_sig("rst.data", S_DATA, 32'h3E);
        expect_state("rst", 1'b0, 0, 1'b0);

        // Unconditional code
        load(16'h0150, 8'h00, 8'h00, 1'b1, 1'b0);
        expect_state("add0150", 1'b1, 1, 1'b0);
        look("hit0150",  16'h0150, 8'h3E, 1'b1, 1'b1, 8'h00);
        look("miss0151", 16'h0151, 8'h3E, 1'b1, 1'b0, 8'h3E);
        look("disabled", 16'h0150, 8'h3E, 1'b0, 1'b0, 8'h3E);

        // Compare-qualified code
        load(16'h4000, 8'hC9, 8'h18, 1'b1, 1'b1);
        expect_state("add4000", 1'b1, 2, 1'b0);
        look("cmp_eq", 16'h4000, 8'hC9, 1'b1, 1'b1, 8'h18);
        look("cmp_ne", 16'h4000, 8'hCA, 1'b1, 1'b0, 8'hCA);

        // Fill the table, then overflow it
        for (int i = 0; i < MC - 2; i++) load(16'h8000 + 16'(i), 8'h00, 8'(i), 1'b1, 1'b0);
        expect_state("full", 1'b1, 16, 1'b0);
        load(16'h9000, 8'h00, 8'h44, 1'b1, 1'b0);
        expect_state("overflow", 1'b1, 16, 1'b1);
        cyc();
        expect_sig("overflow_pulse_end", S_ERR, 32'd0);
        look("rejected9000", 16'h9000, 8'h12, 1'b1, 1'b0, 8'h12);
        look("hit800d", 16'h800D, 8'h00, 1'b1, 1'b1, 8'h0D);

        // Overwrite in place while full
        load(16'h4000, 8'h00, 8'h55, 1'b1, 1'b0);
        expect_state("rewrite4000", 1'b1, 16, 1'b0);
        look("hit4000new", 16'h4000, 8'h77, 1'b1, 1'b1, 8'h55);

        // Back-to-back remove then add
        cyc();
        set_code(16'h0150, 8'h00, 8'h00, 1'b0, 1'b0);
        code_wr = 1'b1;
        cyc();
        set_code(16'h7000, 8'h00, 8'hA5, 1'b1, 1'b0);
        addr_in = 16'h0150;
        data_in = 8'h3E;
        expect_state("removed0150", 1'b1, 15, 1'b0);
        expect_sig("gone0150.ovr", S_OVR, 32'd0);
        cyc();
        code_wr = 1'b0;
        expect_state("add7000", 1'b1, 16, 1'b0);
        look("hit7000",  16'h7000, 8'h01, 1'b1, 1'b1, 8'hA5);
        look("miss0150", 16'h0150, 8'h3E, 1'b1, 1'b0, 8'h3E);
        load(16'h9100, 8'h00, 8'h00, 1'b1, 1'b0);
        expect_state("still_full", 1'b1, 16, 1'b1);

        // Back-to-back add then remove of the same address
        load(16'h7000, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_state("rm7000", 1'b1, 15, 1'b0);
        cyc();
        set_code(16'hB000, 8'h00, 8'h66, 1'b1, 1'b0);
        code_wr = 1'b1;
        cyc();
        set_code(16'hB000, 8'h00, 8'h00, 1'b0, 1'b0);
        addr_in = 16'hB000;
        data_in = 8'h00;
        expect_state("addB000", 1'b1, 16, 1'b0);
        expect_sig("liveB000.ovr", S_OVR, 32'd1);
        expect_sig("liveB000.data", S_DATA, 32'h66);
        cyc();
        code_wr = 1'b0;
        expect_state("rmB000", 1'b1, 15, 1'b0);
        look("goneB000", 16'hB000, 8'h00, 1'b1, 1'b0, 8'h00);

        // Reset beats a simultaneous load
        cyc();
        reset   = 1'b1;
        set_code(16'hC000, 8'h00, 8'h99, 1'b1, 1'b0);
        code_wr = 1'b1;
        cyc();
        reset   = 1'b0;
        code_wr = 1'b0;
        expect_state("rst_wr", 1'b0, 0, 1'b0);
        look("rst_missC000", 16'hC000, 8'h21, 1'b1, 1'b0, 8'h21);
        look("rst_miss8000", 16'h8000, 8'h22, 1'b1, 1'b0, 8'h22);

`ifdef CODES_HIT_STATS_EN
        load(16'h0150, 8'h00, 8'h00, 1'b1, 1'b0);
        addr_in = 16'h0150;
        enable  = 1'b1;
        repeat (5) cyc();
        addr_in  = 16'h0000;
        stat_idx = '0;
        cyc();
        expect_sig("stat_five", S_STAT, 32'd5);
        load(16'h0150, 8'h00, 8'h11, 1'b1, 1'b0);
        cyc();
        expect_sig("stat_cleared", S_STAT, 32'd0);
`endif

        cyc();
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
